// File: rtl/checker_uart_report_pkg.sv
// rtl/checker_uart_report_pkg.sv - shared constants, types and helpers for the UART status reporter
package checker_uart_report_pkg;

    localparam int LINE_LEN = 8;

    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        LINE_IDLE,
        LINE_LOAD,
        LINE_SEND
    } line_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Integer division truncates, so a non-integer ratio rounds the bit time down.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F' ('A' - 10 = 0x37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser with bit-clock divider and valid/ready input
module uart_tx_byte
    import checker_uart_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_q, tx_n;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);
    // Accepting in the last stop-bit cycle lets the next start bit follow with no idle gap.
    assign tready  = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);
    assign tx      = tx_q;

    // State, divider and registered line output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_q    <= tx_n;
        end
    end

    // Next-state logic; tx_n is the level the pin carries from the next cycle on.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx_q;
        case (state)
            TX_IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (tvalid) begin
                    state_n = TX_START;
                    shreg_n = tdata;
                    tx_n    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = TX_DATA;
                    tx_n      = shreg[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (tvalid) begin
                        state_n = TX_START;
                        shreg_n = tdata;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = TX_IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = TX_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/checker_uart_report.sv
// rtl/checker_uart_report.sv - periodic and error-triggered ASCII status line over UART
module checker_uart_report #(
    parameter int CLK_HZ        = 12000000,
    parameter int BAUD          = 115200,
    parameter int REPORT_CYCLES = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chk_done,
    input  logic        chk_error,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] line_count
);
    import checker_uart_report_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int TW = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(LINE_LEN - 1);

    line_state_t   state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          pending, pending_n;
    logic          err_q;
    logic [15:0]   seq_q, seq_n;
    logic [2:0]    byte_idx, byte_idx_n;
    logic          busy_q, busy_n;
    logic [15:0]   line_count_q, line_count_n;

    logic          period_hit;
    logic          err_rise;
    logic          trigger;
    logic [7:0]    status_now;
    logic [2:0]    next_idx;
    logic [7:0]    next_byte;
    logic          tx_tvalid;
    logic          tx_tready;
    logic [7:0]    tx_tdata;

    assign period_hit = (timer == TIMER_LAST);
    assign err_rise   = chk_error && !err_q;
    assign trigger    = period_hit || err_rise;
    assign status_now = chk_error ? ASCII_E : (chk_done ? ASCII_O : ASCII_W);

    assign busy       = busy_q;
    assign line_count = line_count_q;

    // Bytes 1..7 of the line; byte 0 (status) is handed to the serialiser directly in LOAD,
    // where its shift register freezes it for the rest of the line.
    assign next_idx = byte_idx + 3'd1;
    always_comb begin
        next_byte = ASCII_LF;
        case (next_idx)
            3'd1:    next_byte = ASCII_SPACE;
            3'd2:    next_byte = hex_ascii(seq_q[15:12]);
            3'd3:    next_byte = hex_ascii(seq_q[11:8]);
            3'd4:    next_byte = hex_ascii(seq_q[7:4]);
            3'd5:    next_byte = hex_ascii(seq_q[3:0]);
            3'd6:    next_byte = ASCII_CR;
            default: next_byte = ASCII_LF;
        endcase
    end

    // Line FSM, period timer, trigger bookkeeping and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LINE_IDLE;
            timer        <= '0;
            pending      <= 1'b0;
            err_q        <= 1'b0;
            seq_q        <= '0;
            byte_idx     <= '0;
            busy_q       <= 1'b0;
            line_count_q <= '0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            pending      <= pending_n;
            err_q        <= chk_error;
            seq_q        <= seq_n;
            byte_idx     <= byte_idx_n;
            busy_q       <= busy_n;
            line_count_q <= line_count_n;
        end
    end

    // A trigger seen while IDLE moves straight to LOAD so the start bit follows two cycles later.
    always_comb begin
        state_n      = state;
        timer_n      = period_hit ? '0 : timer + TW'(1);
        pending_n    = pending;
        seq_n        = seq_q;
        byte_idx_n   = byte_idx;
        busy_n       = busy_q;
        line_count_n = line_count_q;
        tx_tvalid    = 1'b0;
        tx_tdata     = next_byte;
        case (state)
            LINE_IDLE: begin
                if (pending || trigger) begin
                    state_n = LINE_LOAD;
                end
            end
            LINE_LOAD: begin
                tx_tvalid  = 1'b1;
                tx_tdata   = status_now;
                seq_n      = line_count_q;
                byte_idx_n = '0;
                busy_n     = 1'b1;
                pending_n  = 1'b0;
                state_n    = LINE_SEND;
            end
            LINE_SEND: begin
                if (tx_tready) begin
                    if (byte_idx == LAST_IDX) begin
                        state_n      = LINE_IDLE;
                        busy_n       = 1'b0;
                        line_count_n = line_count_q + 16'd1;
                    end else begin
                        tx_tvalid  = 1'b1;
                        byte_idx_n = next_idx;
                    end
                end
            end
            default: begin
                state_n = LINE_IDLE;
            end
        endcase
        // Set after the LOAD clear so a same-cycle trigger is not lost.
        if (trigger) begin
            pending_n = 1'b1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .tdata  (tx_tdata),
        .tvalid (tx_tvalid),
        .tready (tx_tready),
        .tx     (uart_tx)
    );

endmodule

// File: tb/tb_checker_uart_report.sv
// tb/tb_checker_uart_report.sv - self-checking bench for checker_uart_report
module tb_checker_uart_report;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chk_done = 1'b0;
    logic        chk_error = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic [15:0] line_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_start_q[$];

    logic       tx_prev = 1'b1;
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    int         frame_start = 0;
    int         fall_count = 0;
    int         frame_err = 0;
    logic [7:0] mon_byte = 8'h00;

    checker_uart_report #(
        .CLK_HZ        (1000),
        .BAUD          (100),
        .REPORT_CYCLES (2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chk_done   (chk_done),
        .chk_error  (chk_error),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .line_count (line_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // UART receiver: 10 clocks per bit, samples bit centres on the falling clock edge.
    always @(negedge clk) begin
        tx_prev <= uart_tx;
        if (reset) begin
            mon_busy   <= 1'b0;
            fall_count <= 0;
        end else if (!mon_busy) begin
            if (!uart_tx && tx_prev) begin
                mon_busy    <= 1'b1;
                mon_cnt     <= 0;
                frame_start <= cyc;
                fall_count  <= fall_count + 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 4) begin
                if (uart_tx !== 1'b0) frame_err <= frame_err + 1;
            end else if (mon_cnt == 94) begin
                if (uart_tx !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(mon_byte);
                rx_start_q.push_back(frame_start);
                mon_busy <= 1'b0;
            end else if ((mon_cnt % 10) == 4) begin
                mon_byte[(mon_cnt - 14) / 10] <= uart_tx;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic expect_line(input logic [7:0] st, input logic [15:0] seq);
        exp_q.push_back(st);
        exp_q.push_back(8'h20);
        exp_q.push_back(hexc(seq[15:12]));
        exp_q.push_back(hexc(seq[11:8]));
        exp_q.push_back(hexc(seq[7:4]));
        exp_q.push_back(hexc(seq[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Waits (bounded) for n received bytes and compares them and their frame start cycles.
    task automatic compare_bytes(input string tag, input int n, input int first_start);
        int k;
        logic [7:0] obs;
        logic [7:0] e;
        int st;
        k = 0;
        while (rx_q.size() < n && k < 3000 + 100 * n) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (rx_q.size() < n) check({tag, "_timeout"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            obs = rx_q.pop_front();
            e   = exp_q.pop_front();
            st  = rx_start_q.pop_front();
            check($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(e));
            check($sformatf("%s_start%0d", tag, i), st, first_start + 100 * i);
        end
    endtask

    initial begin
        // Reset state and the first periodic line with no status flags set.
        do_reset();
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_count", 32'(line_count), 32'd0);
        expect_line(8'h57, 16'h0000);
        goto_cyc(1990);
        check("t1_quiet", fall_count, 0);
        compare_bytes("t1_line", 8, 2001);
        goto_cyc(2800);
        check("t1_busy_last_stop", 32'(busy), 32'd1);
        check("t1_count_last_stop", 32'(line_count), 32'd0);
        goto_cyc(2801);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_count_after", 32'(line_count), 32'd1);
        check("t1_tx_idle", 32'(uart_tx), 32'd1);

        // Two periodic lines with chk_done held, 2000 cycles apart.
        chk_done = 1'b1;
        do_reset();
        expect_line(8'h4F, 16'h0000);
        compare_bytes("t2_l0", 8, 2001);
        expect_line(8'h4F, 16'h0001);
        compare_bytes("t2_l1", 8, 4001);

        // Error edge while idle, then a periodic line with the error still held.
        chk_done = 1'b0;
        do_reset();
        goto_cyc(500);
        chk_error = 1'b1;
        expect_line(8'h45, 16'h0000);
        compare_bytes("t3_err", 8, 502);
        expect_line(8'h45, 16'h0001);
        compare_bytes("t3_per", 8, 2001);
        goto_cyc(3990);
        check("t3_no_extra", fall_count, 16);

        // Two error edges during a periodic line coalesce into one following line.
        chk_error = 1'b0;
        chk_done = 1'b1;
        do_reset();
        expect_line(8'h4F, 16'h0000);
        goto_cyc(2300);
        chk_error = 1'b1;
        goto_cyc(2400);
        chk_error = 1'b0;
        goto_cyc(2500);
        chk_error = 1'b1;
        compare_bytes("t4_cur", 8, 2001);
        goto_cyc(2801);
        check("t4_busy_fall", 32'(busy), 32'd0);
        check("t4_count", 32'(line_count), 32'd1);
        expect_line(8'h45, 16'h0001);
        compare_bytes("t4_next", 8, 2803);
        goto_cyc(3990);
        check("t4_one_extra", fall_count, 16);

        // Reset in the middle of byte 3 data bits of the second line.
        chk_error = 1'b0;
        chk_done = 1'b0;
        do_reset();
        expect_line(8'h57, 16'h0000);
        compare_bytes("t5_l0", 8, 2001);
        exp_q.push_back(8'h57);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        compare_bytes("t5_part", 3, 4001);
        goto_cyc(4340);
        check("t5_mid_busy", 32'(busy), 32'd1);
        check("t5_mid_tx", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_tx", 32'(uart_tx), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_count", 32'(line_count), 32'd0);
        reset = 1'b0;
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
        goto_cyc(2000);
        check("t5_no_resume", fall_count, 0);
        check("t5_idle_tx", 32'(uart_tx), 32'd1);
        expect_line(8'h57, 16'h0000);
        compare_bytes("t5_after", 8, 2001);

        // Sequence number wrap from FFFF to 0000.
        do_reset();
        goto_cyc(100);
        force dut.line_count_q = 16'hFFFF;
        goto_cyc(102);
        release dut.line_count_q;
        goto_cyc(110);
        check("t6_forced", 32'(line_count), 32'h0000FFFF);
        expect_line(8'h57, 16'hFFFF);
        compare_bytes("t6_ffff", 8, 2001);
        goto_cyc(2801);
        check("t6_wrapped", 32'(line_count), 32'd0);
        expect_line(8'h57, 16'h0000);
        compare_bytes("t6_wrap", 8, 4001);

        check("frame_errors", frame_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/checker_uart_report.md
Name: checker_uart_report

Overview:
- Downstream consumer of the brownout/memory checker status flags (error, pass-finished) on the iCEstick.
- Periodically, and immediately on a new error, transmits a fixed 8-byte ASCII status line over the FTDI UART TX pin (8N1).
- The host can log board health without watching the LEDs.
- Line format: status char, space, 4 uppercase hex digits of line sequence number, CR, LF. Example: "O 002A\r\n".

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated (104 at defaults); must be >= 2.
- REPORT_CYCLES, 12000000, clocks between periodic reports; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- chk_done  in  1  checker read-back pass finished (level).
- chk_error  in  1  checker sticky error flag (level).
- uart_tx  out  1  serial output, idle high.
- busy  out  1  high while a line is being transmitted.
- line_count  out  16  number of lines fully transmitted; wraps at 16 bits.

Behaviour:
- Reset values: uart_tx=1, busy=0, line_count=0, period timer=0, pending=0, error-edge register=0.
- Reset is synchronous and wins over every other event. Asserted mid-line: uart_tx is 1 the next cycle, the line is abandoned, and nothing resumes.
- Period timer:
  - Counts 0..REPORT_CYCLES-1 continuously, including during transmission.
  - At the terminal count it wraps to 0 and sets pending.
- Error trigger: a rising edge of chk_error (registered compare, 0 in previous cycle, 1 now) sets pending.
- Coalescing: pending is a single flag. Any number of triggers while pending=1 or busy=1 produce exactly one later line.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if pending, go to LOAD the next cycle.
  - LOAD (1 cycle):
    - Snapshot the status char: 'E'(0x45) if chk_error, else 'O'(0x4F) if chk_done, else 'W'(0x57).
    - Snapshot line_count as the sequence value.
    - Clear pending. A trigger in this same cycle wins and leaves pending=1.
    - Set byte index=0, busy=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
    - If byte index<7: increment it and go straight to START. No extra idle bits between bytes.
    - If byte index=7: line_count increments on the last stop-bit cycle, busy drops the same cycle, go to IDLE.
- Byte sequence (index 0..7):
  - 0: status char.
  - 1: 0x20.
  - 2..5: hex digits of the snapshot, MSB nibble first; 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
  - 6: 0x0D.
  - 7: 0x0A.
- Timing:
  - Line duration = 80*CLKS_PER_BIT cycles from the first START cycle (8320 at defaults).
  - Latency from a trigger to the start-bit falling edge is 2 cycles when IDLE.
- Status and sequence are frozen at LOAD. Input changes mid-line do not alter the bytes in flight.
- If REPORT_CYCLES is shorter than the line duration, lines go back to back, one per line time. Extra periodic triggers are coalesced.
- line_count wraps 0xFFFF→0x0000. The next line then reports "0000".

Decomposition:
- Shared package/header holds:
  - ASCII constants: 'E', 'O', 'W', space, CR, LF.
  - Nibble-to-hex-ASCII function.
  - CLKS_PER_BIT derivation.
  - Line length constant 8.
- One sub-module: uart_tx_byte.
  - Handles start/data/stop serialisation with a bit-clock divider.
  - Interface: valid/ready byte handshake, tx out; ready high in the last stop-bit cycle.
- The parent holds the period timer, trigger/pending logic, snapshot, byte mux and line FSM.

Test Plan (sim with CLK_HZ=1000, BAUD=100 → 10 clk/bit; REPORT_CYCLES=2000):
- Reset, chk_done=0, chk_error=0, run 2002 cycles. Required:
  - Start bit at cycle 2001.
  - Decoded line "W 0000\r\n", 800 cycles long.
  - line_count=1 afterwards; uart_tx=1 otherwise.
- chk_done=1 held, run two periods. Required:
  - Lines "O 0000\r\n" then "O 0001\r\n".
  - Start bits exactly 2000 cycles apart.
- chk_error 0→1 at cycle 500 while IDLE. Required:
  - Start bit at cycle 502, line "E 0000\r\n".
  - Next periodic line "E 0001" at 2001.
  - Holding chk_error high causes no extra triggers.
- chk_error rising edge during a periodic line. Required:
  - The current line finishes unchanged (e.g. "O 0003").
  - Exactly one further line "E 0004" follows 2 cycles after busy falls.
- reset asserted mid-DATA of byte 3. Required:
  - uart_tx=1 and busy=0 the next cycle; line_count=0.
  - No further start bit until the next trigger.
- Force line_count to 0xFFFF (or run 65536 lines with REPORT_CYCLES=1). Required: line "xFFFF" is followed by "x0000" with wrap.
